// File: rtl/io_evt_collector.sv
// io_evt_collector
// Gathers single-cycle event pulses from N_SRC sources into one-deep pending
// flags, serialises them with a round-robin arbiter into a FIFO of event IDs
// and offers the FIFO head to the SoC event unit as a valid/ready stream.
// Software-injected events share the FIFO and win over source grants.
// Events that hit an already-pending, non-granted source are dropped and
// counted in a saturating counter with a sticky overflow flag.
//
// Handshake (both streams): a transfer happens on a rising edge where valid
// and ready are both high. On the output side evt_valid_o never depends on
// evt_ready_i, and the head (evt_id_o/evt_ext_o) holds while valid && !ready.
// On the injection side ext_ready_o is combinational (FIFO has room, possibly
// thanks to a pop in the same cycle) and does not depend on ext_valid_i.
module io_evt_collector #(
    parameter int N_SRC      = 128,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    localparam int ID_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_ni,
    input  logic [N_SRC-1:0] src_evt_i,
    input  logic [N_SRC-1:0] src_mask_i,
    input  logic             ext_valid_i,
    input  logic [ID_W-1:0]  ext_id_i,
    output logic             ext_ready_o,
    output logic             evt_valid_o,
    output logic [ID_W-1:0]  evt_id_o,
    output logic             evt_ext_o,
    input  logic             evt_ready_i,
    input  logic             clr_drop_i,
    output logic             overflow_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [LVL_W-1:0] fifo_level_o
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = ID_W + 1;
    localparam int PC_W  = $clog2(N_SRC + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] hit;
    logic [N_SRC-1:0] grant_vec;
    logic [N_SRC-1:0] drop_vec;
    logic [ID_W-1:0]  hi_idx, lo_idx, grant_idx;
    logic             hi_found, lo_found;
    logic [LVL_W-1:0] level;
    logic             pop, can_push, push_ext, do_grant, push;
    logic [EW-1:0]    push_data;
    logic [EW-1:0]    head;
    logic [PC_W-1:0]  drop_num;
    logic [SUM_W-1:0] drop_sum;

    assign hit   = src_evt_i & src_mask_i;
    assign level = wptr_q - rptr_q;
    assign head  = mem_q[rptr_q[AW-1:0]];

    // Round-robin search: lowest pending index at or above the pointer,
    // falling back to the lowest pending index overall (the wrap case).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (i >= int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Push arbitration: an injected event pre-empts any source grant, and at
    // most one entry enters the FIFO per cycle. A full FIFO still accepts a
    // push when the head is being popped in the same cycle.
    always_comb begin
        pop       = evt_valid_o & evt_ready_i;
        can_push  = (level < LVL_W'(FIFO_DEPTH)) ||
                    ((level == LVL_W'(FIFO_DEPTH)) && pop);
        push_ext  = ext_valid_i & can_push;
        do_grant  = can_push & ~ext_valid_i & lo_found;
        push      = push_ext | do_grant;
        push_data = push_ext ? {1'b1, ext_id_i} : {1'b0, grant_idx};
        grant_vec = '0;
        if (do_grant) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Pending flags, pointer update and drop detection. A granted source that
    // pulses again in the same cycle simply stays pending (no drop).
    always_comb begin
        pending_d = (pending_q & ~grant_vec) | hit;
        drop_vec  = hit & pending_q & ~grant_vec;
        rr_d      = rr_q;
        if (do_grant) begin
            if (int'(grant_idx) == N_SRC - 1) begin
                rr_d = '0;
            end else begin
                rr_d = grant_idx + ID_W'(1);
            end
        end
    end

    // Drop accounting: clear takes effect first, then this cycle's drops are
    // added as a popcount with saturation.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < N_SRC; i++) begin
            drop_num = drop_num + PC_W'(drop_vec[i]);
        end
        drop_sum   = (clr_drop_i ? '0 : SUM_W'(drop_cnt_q)) + SUM_W'(drop_num);
        drop_cnt_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
        overflow_d = (clr_drop_i ? 1'b0 : overflow_q) | (|drop_vec);
    end

    // FIFO pointers carry an extra MSB so full and empty differ.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            pending_q  <= '0;
            rr_q       <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

    // Outputs are derived from registered state only (except ext_ready_o);
    // the head is forced to zero when the FIFO is empty.
    always_comb begin
        ext_ready_o  = can_push;
        evt_valid_o  = (level != '0);
        evt_id_o     = evt_valid_o ? head[ID_W-1:0] : '0;
        evt_ext_o    = evt_valid_o ? head[EW-1] : 1'b0;
        overflow_o   = overflow_q;
        drop_cnt_o   = drop_cnt_q;
        fifo_level_o = level;
    end

endmodule
